// File: rtl/omsp_spi_arb.sv
`default_nettype none
// omsp_spi_arb: two-requester round-robin front end for an openMSP430 SPI peripheral
// (config write, data write, wait for done, RX read, response).  Rev 1.0
module omsp_spi_arb #(
  parameter logic [13:0] CFG_ADDR  = 14'h0049,
  parameter logic [13:0] DATA_ADDR = 14'h0048,
  parameter int unsigned TIMEOUT   = 1023
) (
  input  logic        mclk,
  input  logic        puc_rst,
  input  logic        r0_req,
  input  logic [7:0]  r0_cfg,
  input  logic [7:0]  r0_txd,
  output logic        r0_ack,
  output logic [7:0]  r0_rxd,
  output logic        r0_err,
  input  logic        r1_req,
  input  logic [7:0]  r1_cfg,
  input  logic [7:0]  r1_txd,
  output logic        r1_ack,
  output logic [7:0]  r1_rxd,
  output logic        r1_err,
  output logic [13:0] per_addr,
  output logic [15:0] per_din,
  output logic        per_en,
  output logic [1:0]  per_we,
  input  logic [15:0] per_dout,
  input  logic        spi_irq_tx_done,
  output logic [1:0]  spi_cs_n,
  output logic        busy
);

  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WR_CFG    = 3'd1,
    S_WR_DATA   = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_RD_DATA   = 3'd4,
    S_RESP      = 3'd5
  } state_t;

  state_t           state_q;
  logic             prio_q;
  logic             win_q;
  logic [7:0]       txd_q;
  logic [CNT_W-1:0] cnt_q;
  logic             per_en_q;
  logic [1:0]       per_we_q;
  logic [13:0]      per_addr_q;
  logic [15:0]      per_din_q;
  logic [1:0]       cs_n_q;
  logic [1:0]       ack_q;
  logic [1:0]       err_q;
  logic [7:0]       rxd0_q;
  logic [7:0]       rxd1_q;
  logic             win_d;
  logic             unused_dout_hi;

  // Contention goes to the priority holder; a lone requester always wins.
  always_comb begin
    win_d = r1_req;
    if (r0_req && r1_req) begin
      win_d = prio_q;
    end
  end

  always_ff @(posedge mclk) begin
    if (puc_rst) begin
      state_q    <= S_IDLE;
      prio_q     <= 1'b0;
      win_q      <= 1'b0;
      txd_q      <= 8'h00;
      cnt_q      <= '0;
      per_en_q   <= 1'b0;
      per_we_q   <= 2'b00;
      per_addr_q <= 14'h0000;
      per_din_q  <= 16'h0000;
      cs_n_q     <= 2'b11;
      ack_q      <= 2'b00;
      err_q      <= 2'b00;
      rxd0_q     <= 8'h00;
      rxd1_q     <= 8'h00;
    end else begin
      ack_q      <= 2'b00;
      per_en_q   <= 1'b0;
      per_we_q   <= 2'b00;
      per_addr_q <= 14'h0000;
      per_din_q  <= 16'h0000;
      case (state_q)
        S_IDLE: begin
          if (r0_req || r1_req) begin
            win_q      <= win_d;
            txd_q      <= win_d ? r1_txd : r0_txd;
            cs_n_q     <= win_d ? 2'b01 : 2'b10;
            per_en_q   <= 1'b1;
            per_we_q   <= 2'b01;
            per_addr_q <= CFG_ADDR;
            per_din_q  <= {8'h00, (win_d ? r1_cfg : r0_cfg)};
            state_q    <= S_WR_CFG;
          end
        end
        S_WR_CFG: begin
          per_en_q   <= 1'b1;
          per_we_q   <= 2'b01;
          per_addr_q <= DATA_ADDR;
          per_din_q  <= {8'h00, txd_q};
          state_q    <= S_WR_DATA;
        end
        S_WR_DATA: begin
          cnt_q   <= '0;
          state_q <= S_WAIT_DONE;
        end
        S_WAIT_DONE: begin
          // Done is checked first so it beats a simultaneous timeout.
          if (spi_irq_tx_done) begin
            per_en_q   <= 1'b1;
            per_addr_q <= DATA_ADDR;
            state_q    <= S_RD_DATA;
          end else if (cnt_q == CNT_LAST) begin
            ack_q[win_q] <= 1'b1;
            err_q[win_q] <= 1'b1;
            if (win_q) rxd1_q <= 8'h00;
            else       rxd0_q <= 8'h00;
            state_q <= S_RESP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_RD_DATA: begin
          ack_q[win_q] <= 1'b1;
          err_q[win_q] <= 1'b0;
          if (win_q) rxd1_q <= per_dout[7:0];
          else       rxd0_q <= per_dout[7:0];
          state_q <= S_RESP;
        end
        S_RESP: begin
          cs_n_q  <= 2'b11;
          prio_q  <= ~win_q;
          state_q <= S_IDLE;
        end
        default: begin
          cs_n_q  <= 2'b11;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign unused_dout_hi = ^per_dout[15:8];

  assign r0_ack   = ack_q[0];
  assign r1_ack   = ack_q[1];
  assign r0_err   = err_q[0];
  assign r1_err   = err_q[1];
  assign r0_rxd   = rxd0_q;
  assign r1_rxd   = rxd1_q;
  assign per_en   = per_en_q;
  assign per_we   = per_we_q;
  assign per_addr = per_addr_q;
  assign per_din  = per_din_q;
  assign spi_cs_n = cs_n_q;
  assign busy     = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_omsp_spi_arb.sv
`default_nettype none
// tb_omsp_spi_arb: directed transactions against a cycle-indexed timeline of expected outputs.
module tb_omsp_spi_arb;
  localparam int          TO   = 20;
  localparam logic [13:0] CFGA = 14'h0049;
  localparam logic [13:0] DATA = 14'h0048;
  localparam int          MAXC = 2048;

  logic mclk = 1'b0, puc_rst = 1'b1;
  logic r0_req = 1'b0, r1_req = 1'b0;
  logic [7:0] r0_cfg = 8'h00, r0_txd = 8'h00, r1_cfg = 8'h00, r1_txd = 8'h00;
  logic r0_ack, r1_ack, r0_err, r1_err, per_en, busy;
  logic [7:0] r0_rxd, r1_rxd;
  logic [13:0] per_addr;
  logic [15:0] per_din;
  logic [1:0] per_we, spi_cs_n;
  logic [15:0] per_dout = 16'hBEEF;
  logic spi_irq_tx_done = 1'b0;

  always #5 mclk = ~mclk;

  omsp_spi_arb #(.CFG_ADDR(CFGA), .DATA_ADDR(DATA), .TIMEOUT(TO)) dut (
    .mclk(mclk), .puc_rst(puc_rst),
    .r0_req(r0_req), .r0_cfg(r0_cfg), .r0_txd(r0_txd), .r0_ack(r0_ack), .r0_rxd(r0_rxd), .r0_err(r0_err),
    .r1_req(r1_req), .r1_cfg(r1_cfg), .r1_txd(r1_txd), .r1_ack(r1_ack), .r1_rxd(r1_rxd), .r1_err(r1_err),
    .per_addr(per_addr), .per_din(per_din), .per_en(per_en), .per_we(per_we), .per_dout(per_dout),
    .spi_irq_tx_done(spi_irq_tx_done), .spi_cs_n(spi_cs_n), .busy(busy)
  );

  int cyc = 0;
  always @(posedge mclk) cyc <= cyc + 1;

  // Expected value of every output, indexed by cycle number.
  logic [1:0]  e_cs   [MAXC];
  logic        e_en   [MAXC];
  logic [1:0]  e_we   [MAXC];
  logic [13:0] e_addr [MAXC];
  logic [15:0] e_din  [MAXC];
  logic [1:0]  e_ack  [MAXC];
  logic [1:0]  e_err  [MAXC];
  logic [7:0]  e_rxd0 [MAXC];
  logic [7:0]  e_rxd1 [MAXC];

  int checks = 0, errors = 0, m_prio = 0, last_ack = -1;
  int ack_cyc[2] = '{0, 0};
  int ack_cnt[2] = '{0, 0};
  bit chk_en = 1'b0;
  logic [29:0] wr_log[$];

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endfunction

  function automatic void clear_from(int c);
    for (int i = c; i < MAXC; i++) begin
      e_cs[i] = 2'b11; e_en[i] = 1'b0; e_we[i] = 2'b00; e_addr[i] = '0; e_din[i] = '0;
      e_ack[i] = 2'b00; e_err[i] = 2'b00; e_rxd0[i] = 8'h00; e_rxd1[i] = 8'h00;
    end
  endfunction

  always @(negedge mclk) begin
    if (chk_en) begin
      if (cyc >= MAXC) begin
        $display("FAIL cycle_budget cycle %0d: got over %0d expected under", cyc, MAXC);
        $fatal(1, "cycle budget exhausted");
      end
      chk("cs_n",     32'(spi_cs_n),          32'(e_cs[cyc]));
      chk("busy",     32'(busy),              32'(e_cs[cyc] != 2'b11));
      chk("per_en",   32'(per_en),            32'(e_en[cyc]));
      chk("per_we",   32'(per_we),            32'(e_we[cyc]));
      chk("per_addr", 32'(per_addr),          32'(e_addr[cyc]));
      chk("per_din",  32'(per_din),           32'(e_din[cyc]));
      chk("ack",      32'({r1_ack, r0_ack}),  32'(e_ack[cyc]));
      chk("err",      32'({r1_err, r0_err}),  32'(e_err[cyc]));
      chk("r0_rxd",   32'(r0_rxd),            32'(e_rxd0[cyc]));
      chk("r1_rxd",   32'(r1_rxd),            32'(e_rxd1[cyc]));
      if (per_en === 1'b1 && per_we !== 2'b00) wr_log.push_back({per_addr, per_din});
      if (r0_ack === 1'b1) begin ack_cyc[0] = cyc; ack_cnt[0]++; last_ack = 0; end
      if (r1_ack === 1'b1) begin ack_cyc[1] = cyc; ack_cnt[1]++; last_ack = 1; end
    end
  end

  // Called in an IDLE cycle; returns in the IDLE cycle after the transaction.
  // dly: cycles from request sample to done (0 = never); rst_at: cycle offset to reset (0 = none).
  task automatic run_txn(input bit q0, input bit q1, input logic [7:0] c0, input logic [7:0] x0,
                         input logic [7:0] c1, input logic [7:0] x1, input int dly,
                         input logic [15:0] dout, input bit spur, input bit early, input int rst_at);
    int t0, w, r, last;
    bit ok;
    logic [7:0] cfg, txd;
    t0 = cyc;
    r0_req = q0; r1_req = q1; r0_cfg = c0; r0_txd = x0; r1_cfg = c1; r1_txd = x1;
    w   = (q0 && q1) ? m_prio : (q1 ? 1 : 0);
    cfg = (w == 1) ? c1 : c0;
    txd = (w == 1) ? x1 : x0;
    ok  = (dly >= 3) && (dly <= TO + 2);
    r   = ok ? t0 + dly + 2 : t0 + TO + 3;
    for (int i = t0 + 1; i <= r; i++) e_cs[i] = (w == 1) ? 2'b01 : 2'b10;
    e_en[t0+1] = 1'b1; e_we[t0+1] = 2'b01; e_addr[t0+1] = CFGA; e_din[t0+1] = {8'h00, cfg};
    e_en[t0+2] = 1'b1; e_we[t0+2] = 2'b01; e_addr[t0+2] = DATA; e_din[t0+2] = {8'h00, txd};
    if (ok) begin
      e_en[t0+dly+1] = 1'b1; e_we[t0+dly+1] = 2'b00; e_addr[t0+dly+1] = DATA; e_din[t0+dly+1] = '0;
    end
    e_ack[r] = (w == 1) ? 2'b10 : 2'b01;
    for (int i = r; i < MAXC; i++) begin
      if (w == 1) e_rxd1[i] = ok ? dout[7:0] : 8'h00;
      else        e_rxd0[i] = ok ? dout[7:0] : 8'h00;
      e_err[i][w] = !ok;
    end
    m_prio = 1 - w;
    if (rst_at != 0) begin
      clear_from(t0 + rst_at + 1);
      m_prio = 0;
    end
    last = (rst_at != 0) ? rst_at : r - t0;
    for (int k = 1; k <= last; k++) begin
      @(posedge mclk); #1;
      if (k == 1) begin
        r0_cfg = ~c0; r0_txd = x0 ^ 8'h5A; r1_cfg = c1 + 8'd17; r1_txd = ~x1;
      end
      spi_irq_tx_done = (dly != 0 && k == dly) || (spur && (k == 1 || k == r - t0));
      per_dout = (dly != 0 && k == dly + 1) ? dout : (16'hBE00 | 16'(k));
      if ((early && k == 2) || k == r - t0) begin
        if (w == 1) r1_req = 1'b0;
        else        r0_req = 1'b0;
      end
      if (rst_at != 0 && k == rst_at) puc_rst = 1'b1;
    end
    @(posedge mclk); #1;
    spi_irq_tx_done = 1'b0;
    per_dout = 16'hBEEF;
    if (rst_at != 0) begin
      puc_rst = 1'b0; r0_req = 1'b0; r1_req = 1'b0;
      @(posedge mclk); #1;
    end
  endtask

  task automatic do_reset();
    puc_rst = 1'b1; r0_req = 1'b0; r1_req = 1'b0;
    @(posedge mclk); #1;
    clear_from(cyc);
    m_prio = 0;
    puc_rst = 1'b0;
    @(posedge mclk); #1;
  endtask

  initial begin
    int t0, n;
    clear_from(0);
    @(posedge mclk); #1;
    chk_en = 1'b1;
    @(posedge mclk); #1;
    chk("rst_cs_n", 32'(spi_cs_n), 32'h3);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_per",  32'({per_en, per_we, per_addr[7:0], per_din[7:0]}), 32'h0);
    chk("rst_rxd",  32'({r1_rxd, r0_rxd, r1_ack, r0_ack, r1_err, r0_err}), 32'h0);
    puc_rst = 1'b0;
    @(posedge mclk); #1;

    // Basic single transfer with literal expectations.
    wr_log.delete();
    t0 = cyc;
    run_txn(1, 0, 8'hAD, 8'h41, 8'h00, 8'h00, 10, 16'h00C3, 0, 0, 0);
    chk("r038_nwr",  32'(wr_log.size()), 32'd2);
    chk("r038_wr0",  32'(wr_log[0]), 32'({14'h0049, 16'h00AD}));
    chk("r038_wr1",  32'(wr_log[1]), 32'({14'h0048, 16'h0041}));
    chk("r038_lat",  32'(ack_cyc[0] - t0), 32'd12);
    chk("r038_rxd",  32'(r0_rxd), 32'hC3);
    chk("r038_err",  32'(r0_err), 32'h0);

    // Round robin with both requesting continuously.
    do_reset();
    run_txn(1, 1, 8'h11, 8'h22, 8'h33, 8'h44, 3, 16'hA59C, 0, 0, 0);
    chk("rr_first", 32'(last_ack), 32'd0);
    run_txn(1, 1, 8'h55, 8'h66, 8'h77, 8'h88, 5, 16'h3CB7, 0, 0, 0);
    chk("rr_second", 32'(last_ack), 32'd1);
    run_txn(1, 1, 8'h99, 8'hAA, 8'hBB, 8'hCC, 7, 16'hF0E1, 0, 0, 0);
    chk("rr_third", 32'(last_ack), 32'd0);
    r0_req = 1'b0; r1_req = 1'b0;
    @(posedge mclk); #1;

    // Timeout: no done ever.
    t0 = cyc;
    run_txn(0, 1, 8'h01, 8'h02, 8'h5C, 8'hE7, 0, 16'h0000, 0, 0, 0);
    chk("to_lat",  32'(ack_cyc[1] - t0), 32'(TO + 3));
    chk("to_err",  32'(r1_err), 32'h1);
    chk("to_rxd",  32'(r1_rxd), 32'h0);
    chk("to_cs_n", 32'(spi_cs_n), 32'h3);

    // Spurious done pulses in WR_CFG and RESP are ignored.
    run_txn(1, 0, 8'h3E, 8'h9D, 8'h00, 8'h00, 6, 16'h12D4, 1, 0, 0);
    chk("spur_rxd", 32'(r0_rxd), 32'hD4);

    // Reset while waiting for done aborts without ack.
    n = ack_cnt[0] + ack_cnt[1];
    run_txn(1, 0, 8'h27, 8'h63, 8'h00, 8'h00, 0, 16'h0000, 0, 0, 5);
    chk("rst_noack", 32'(ack_cnt[0] + ack_cnt[1]), 32'(n));
    chk("rst_idle",  32'({busy, spi_cs_n}), 32'h3);
    run_txn(1, 0, 8'h48, 8'hB1, 8'h00, 8'h00, 4, 16'h77E6, 0, 0, 0);
    chk("rst_after", 32'(r0_rxd), 32'hE6);

    // Done on the last counted cycle wins over the timeout.
    t0 = cyc;
    run_txn(0, 1, 8'h00, 8'h00, 8'hC8, 8'h19, TO + 2, 16'h7E81, 0, 0, 0);
    chk("edge_err", 32'(r1_err), 32'h0);
    chk("edge_rxd", 32'(r1_rxd), 32'h81);
    chk("edge_lat", 32'(ack_cyc[1] - t0), 32'(TO + 4));

    // Request dropped mid-transfer still completes; lone requester wins regardless of priority.
    run_txn(1, 0, 8'h6B, 8'h2F, 8'h00, 8'h00, 8, 16'h44F9, 0, 1, 0);
    chk("early_rxd", 32'(r0_rxd), 32'hF9);
    run_txn(1, 0, 8'h0F, 8'hF0, 8'h00, 8'h00, 3, 16'h9E3A, 0, 0, 0);
    chk("lone_win", 32'(last_ack), 32'd0);
    run_txn(1, 1, 8'h1D, 8'h2E, 8'h3F, 8'h4A, 4, 16'h0B5D, 0, 0, 0);
    chk("rr_after_lone", 32'(last_ack), 32'd1);
    r0_req = 1'b0; r1_req = 1'b0;

    repeat (4) begin @(posedge mclk); #1; end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
